req_responder: RTL and testbench
================================

Name: req_responder

Overview:
- Target end of the request interface: consumes up to 4 request lines, which are level or single-shot pulses from the initiator side.
- Latches each request edge as pending and arbitrates round-robin between pending channels.
- Holds the granted channel busy for a programmable service time, then returns a one-hot acknowledge to the requester.
- The 2-bit grant index uses the same encoding as the 4-way select used elsewhere in the design.

Parameters:
- SERVICE_CYCLES, 4, number of cycles spent in BUSY per grant; a value of 0 is treated as 1.
- CNT_W, 8, width of the service down-counter; must hold SERVICE_CYCLES-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; only a rising edge counts as a request.
- cancel  input  1  abort the current service while BUSY.
- busy  output  1  high in BUSY and ACK states.
- grant_idx  output  2  index of the channel currently or last granted.
- ack  output  4  one-hot acknowledge.
- pending  output  4  latched, not-yet-granted requests.
- overflow  output  1  sticky flag: a request edge was dropped.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_q=0; pending=0; ack=0; busy=0; grant_idx=0; overflow=0; cnt=0; rr_ptr=3, so channel 0 wins first. Any in-flight service is dropped and no ack is emitted.
- All outputs are registered.
- Edge detect: rise = req & ~req_q, with req_q <= req every cycle.
- Pending set: pending[i] is set on rise[i].
- Pending clear: pending[i] is cleared on the IDLE->BUSY transition that grants channel i.
- Simultaneous rise[i] and grant-clear of i: pending[i] stays 1, i.e. the new request is kept.
- Rise on an already-pending channel that is not being cleared: the edge is dropped and overflow is set; overflow is cleared only by reset.
- Arbiter: scan channels rr_ptr+1, rr_ptr+2, ... modulo 4; the first pending channel wins. rr_ptr <= winner on grant.
- FSM, IDLE:
  - If pending != 0 -> BUSY.
  - grant_idx <= winner; cnt <= SERVICE_CYCLES-1; busy <= 1.
- FSM, BUSY:
  - cancel=1 -> IDLE; busy <= 0; no ack; the channel is not re-pended. cancel has priority over counter expiry.
  - Else if cnt==0 -> ACK; ack <= onehot(grant_idx).
  - Else cnt <= cnt-1.
- FSM, ACK: for one cycle -> IDLE; ack <= 0; busy <= 0. cancel is ignored in ACK.
- Latency:
  - req sampled high at edge 0 -> pending at edge 0.
  - busy/grant_idx at edge 1.
  - ack high after edge SERVICE_CYCLES+1, for exactly one cycle.
  - IDLE again at edge SERVICE_CYCLES+2.
- Back-to-back: IDLE grants on the first cycle it sees pending, so throughput is one grant per SERVICE_CYCLES+2 cycles.
- grant_idx holds its last value outside BUSY/ACK.
- Requests on any channel, including the granted one, keep accumulating during BUSY/ACK.

Optional Feature:
- Macro: RESP_ACK_HOLD_EN.
- Defined (4-phase handshake):
  - ACK state holds ack[grant_idx]=1 and busy=1 until req[grant_idx] is sampled 0.
  - Then -> IDLE, with ack and busy cleared on that same edge.
  - Other channels continue to pend meanwhile.
- Not defined: ACK lasts exactly one cycle, as specified above; req is never consulted in ACK.

Test Plan:
- Single request, SERVICE_CYCLES=4, reset released: req=4'b0010 rises at edge 0 -> pending=0010 at edge 0; busy=1, grant_idx=1, pending=0000 at edge 1; ack=0010 only after edge 5; busy=0 at edge 6.
- Simultaneous requests req=4'b1111 from reset -> grant order 0,1,2,3; each ack is 1 cycle; grants spaced 6 cycles apart; overflow stays 0.
- Cancel: grant channel 2, assert cancel at edge 3 -> IDLE at edge 3; busy=0; ack never asserted; pending[2]=0.
- Overflow: pulse req[3] twice while channel 0 is BUSY -> second edge sets overflow=1; channel 3 is served exactly once; overflow stays 1 until rst_n=0.
- Async reset in BUSY: drop rst_n mid-cycle at cnt=2 -> busy, ack, pending and overflow are 0 immediately; after release, req[0] is granted first.
- RESP_ACK_HOLD_EN defined: hold req[1] high for 20 cycles -> ack=0010 held from edge 5 until req[1] is sampled low; IDLE on that edge; a pending req[0] is granted on the next edge.

Source files
------------

// File: rtl/req_responder_if.sv
// Request/acknowledge bundle between an initiator (master) and req_responder (slave).
interface req_responder_if;
    logic [3:0] req;
    logic       cancel;
    logic       busy;
    logic [1:0] grant_idx;
    logic [3:0] ack;
    logic [3:0] pending;
    logic       overflow;

    modport master (output req, cancel, input busy, grant_idx, ack, pending, overflow);
    modport slave  (input req, cancel, output busy, grant_idx, ack, pending, overflow);
endinterface

// File: rtl/req_responder.sv
// Round-robin request responder: edge-latched pending, timed BUSY service, one-hot ack.
// Define RESP_ACK_HOLD_EN to hold ack until the granted req drops (4-phase handshake).

module req_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    output logic pending,
    output logic drop
);
    logic req_q;
    logic rise;

    assign rise = req & ~req_q;
    // A fresh edge wins over a same-cycle grant clear; only a stacked edge is lost.
    assign drop = rise & pending & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= rise | (pending & ~clr);
        end
    end
endmodule

module req_responder #(
    parameter int SERVICE_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input logic            clk,
    input logic            rst_n,
    req_responder_if.slave bus
);
    localparam int NUM_CH = 4;
    localparam int SVC    = (SERVICE_CYCLES < 1) ? 1 : SERVICE_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SVC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          rr_ptr;
    logic [1:0]          winner;
    logic [1:0]          idx;
    logic                win_vld;
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   clr;
    logic [NUM_CH-1:0]   drop;
    logic                busy_r;
    logic [1:0]          grant_r;
    logic [NUM_CH-1:0]   ack_r;
    logic                ovf_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        req_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (bus.req[i]),
            .clr     (clr[i]),
            .pending (pend[i]),
            .drop    (drop[i])
        );
    end

    // Scan from the channel after the last winner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        winner  = rr_ptr;
        idx     = rr_ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = rr_ptr + 2'(k);
            if (!win_vld && pend[idx]) begin
                win_vld = 1'b1;
                winner  = idx;
            end
        end
    end

    assign clr = (state == IDLE && win_vld) ? (NUM_CH'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_ptr  <= 2'd3;
            busy_r  <= 1'b0;
            grant_r <= 2'd0;
            ack_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (|drop);
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= BUSY;
                        grant_r <= winner;
                        rr_ptr  <= winner;
                        cnt     <= CNT_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.cancel) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ACK;
                        ack_r <= NUM_CH'(1) << grant_r;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK: begin
`ifdef RESP_ACK_HOLD_EN
                    if (!bus.req[grant_r]) begin
                        state  <= IDLE;
                        ack_r  <= '0;
                        busy_r <= 1'b0;
                    end
`else
                    state  <= IDLE;
                    ack_r  <= '0;
                    busy_r <= 1'b0;
`endif
                end
                default: begin
                    state  <= IDLE;
                    ack_r  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pending   = pend;
    assign bus.busy      = busy_r;
    assign bus.grant_idx = grant_r;
    assign bus.ack       = ack_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_req_responder.sv
// Directed bench for req_responder with a grant-order scoreboard on ack rising edges.
module tb_req_responder;
    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;
    int   sb[$];
    int   exp_ch;
    logic [3:0] ack_prev;

    req_responder_if bus ();

    req_responder #(.SERVICE_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every new ack must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (bus.ack != 4'b0 && ack_prev == 4'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                exp_ch = sb.pop_front();
                check("ack_order", 32'(bus.ack), 32'(1) << exp_ch);
            end
        end
        ack_prev = bus.ack;
    end

    initial begin
        vectors    = 0;
        errs       = 0;
        ack_prev   = 4'b0;
        rst_n      = 1'b0;
        bus.req    = 4'b0;
        bus.cancel = 1'b0;
        tick(2);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_pend", 32'(bus.pending), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_grant", 32'(bus.grant_idx), 32'd0);
        rst_n = 1'b1;

        // single request on channel 1
        bus.req = 4'b0010; sb.push_back(1);
        tick(1);
        check("t1_pend", 32'(bus.pending), 32'b0010);
        check("t1_busy_e0", 32'(bus.busy), 32'd0);
        tick(1);
        check("t1_busy_e1", 32'(bus.busy), 32'd1);
        check("t1_grant", 32'(bus.grant_idx), 32'd1);
        check("t1_pend_clr", 32'(bus.pending), 32'd0);
        bus.req = 4'b0;
        tick(3);
        check("t1_ack_e4", 32'(bus.ack), 32'd0);
        tick(1);
        check("t1_ack_e5", 32'(bus.ack), 32'b0010);
        tick(1);
        check("t1_ack_e6", 32'(bus.ack), 32'd0);
        check("t1_busy_e6", 32'(bus.busy), 32'd0);

        // all four from reset: round-robin order 0..3, 6 cycles apart
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) sb.push_back(k);
        tick(1);
        check("t2_pend", 32'(bus.pending), 32'b1111);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t2_busy", 32'(bus.busy), 32'd1);
            check("t2_grant", 32'(bus.grant_idx), 32'(k));
            tick(4);
            check("t2_ack", 32'(bus.ack), 32'(1) << k);
            tick(1);
            check("t2_ack_off", 32'(bus.ack), 32'd0);
            check("t2_idle", 32'(bus.busy), 32'd0);
        end
        check("t2_ovf", 32'(bus.overflow), 32'd0);
        bus.req = 4'b0;
        tick(1);

        // cancel during service of channel 2
        bus.req = 4'b0100;
        tick(1);
        check("t3_pend", 32'(bus.pending), 32'b0100);
        tick(1);
        check("t3_grant", 32'(bus.grant_idx), 32'd2);
        bus.req = 4'b0;
        tick(1);
        bus.cancel = 1'b1;
        tick(1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        check("t3_ack", 32'(bus.ack), 32'd0);
        check("t3_pend_clr", 32'(bus.pending), 32'd0);
        bus.cancel = 1'b0;
        tick(6);
        check("t3_stay_idle", 32'(bus.busy), 32'd0);

        // new edge on a channel in the same cycle it is granted is kept
        bus.req = 4'b0001; sb.push_back(0);
        tick(2);
        bus.req = 4'b0010; sb.push_back(1);
        tick(1);
        check("t5_pend", 32'(bus.pending), 32'b0010);
        bus.req = 4'b0;
        tick(4);
        check("t5_idle", 32'(bus.busy), 32'd0);
        bus.req = 4'b0010; sb.push_back(1);
        tick(1);
        check("t5_grant", 32'(bus.grant_idx), 32'd1);
        check("t5_pend_kept", 32'(bus.pending), 32'b0010);
        check("t5_ovf", 32'(bus.overflow), 32'd0);
        bus.req = 4'b0;
        tick(6);
        check("t5_regrant", 32'(bus.grant_idx), 32'd1);
        check("t5_busy2", 32'(bus.busy), 32'd1);
        check("t5_pend_clr", 32'(bus.pending), 32'd0);
        tick(5);
        check("t5_done", 32'(bus.busy), 32'd0);

        // double pulse on channel 3 while channel 0 is busy
        bus.req = 4'b0001; sb.push_back(0);
        tick(2);
        check("t4_grant0", 32'(bus.grant_idx), 32'd0);
        bus.req = 4'b1001; sb.push_back(3);
        tick(1);
        check("t4_pend3", 32'(bus.pending), 32'b1000);
        check("t4_ovf_pre", 32'(bus.overflow), 32'd0);
        bus.req = 4'b0001;
        tick(1);
        bus.req = 4'b1001;
        tick(1);
        check("t4_ovf_set", 32'(bus.overflow), 32'd1);
        check("t4_pend_one", 32'(bus.pending), 32'b1000);
        bus.req = 4'b0;
        tick(3);
        check("t4_grant3", 32'(bus.grant_idx), 32'd3);
        check("t4_pend_clr", 32'(bus.pending), 32'd0);
        tick(5);
        check("t4_idle", 32'(bus.busy), 32'd0);
        tick(6);
        check("t4_once", 32'(bus.busy), 32'd0);
        check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // async reset mid-service
        bus.req = 4'b0100; sb.push_back(2);
        tick(2);
        check("t6_grant2", 32'(bus.grant_idx), 32'd2);
        bus.req = 4'b0110;
        tick(1);
        check("t6_pend_pre", 32'(bus.pending), 32'b0010);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_ack", 32'(bus.ack), 32'd0);
        check("t6_pend", 32'(bus.pending), 32'd0);
        check("t6_ovf", 32'(bus.overflow), 32'd0);
        bus.req = 4'b0;
        tick(1);
        rst_n = 1'b1;
        bus.req = 4'b1001; sb.push_back(0); sb.push_back(3);
        tick(1);
        check("t6_pend_post", 32'(bus.pending), 32'b1001);
        tick(1);
        check("t6_first", 32'(bus.grant_idx), 32'd0);
        tick(11);
        check("t6_done", 32'(bus.busy), 32'd0);
        check("t6_grant_hold", 32'(bus.grant_idx), 32'd3);
        bus.req = 4'b0;
        tick(1);

        // ack duration while the granted req stays high
        bus.req = 4'b0010; sb.push_back(1); sb.push_back(0);
        tick(2);
        check("t7_grant1", 32'(bus.grant_idx), 32'd1);
        bus.req = 4'b0011;
        tick(4);
        check("t7_ack", 32'(bus.ack), 32'b0010);
`ifdef RESP_ACK_HOLD_EN
        for (int e = 6; e < 20; e++) begin
            tick(1);
            check("t7_ack_hold", 32'(bus.ack), 32'b0010);
            check("t7_busy_hold", 32'(bus.busy), 32'd1);
        end
        bus.req = 4'b0001;
        tick(1);
        check("t7_ack_rel", 32'(bus.ack), 32'd0);
        check("t7_busy_rel", 32'(bus.busy), 32'd0);
`else
        tick(1);
        check("t7_ack_rel", 32'(bus.ack), 32'd0);
        check("t7_busy_rel", 32'(bus.busy), 32'd0);
`endif
        tick(1);
        check("t7_grant0", 32'(bus.grant_idx), 32'd0);
        check("t7_busy0", 32'(bus.busy), 32'd1);
        bus.req = 4'b0;
        tick(6);
        check("t7_done", 32'(bus.busy), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
